// File: rtl/pc_seq_pkg.sv
// Shared op encodings and the alignment helper for the PC sequencer.
package pc_seq_pkg;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_INC    = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_JUMP   = 3'd3;
  localparam logic [2:0] OP_CALL   = 3'd4;
  localparam logic [2:0] OP_RET    = 3'd5;

  // True when the low align_bits bits of addr are all zero.
  function automatic logic is_aligned(input logic [63:0] addr, input int unsigned align_bits);
    logic [63:0] mask_s;
    mask_s = (64'd1 << align_bits) - 64'd1;
    return ((addr & mask_s) == 64'd0);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         ovf
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(RAS_DEPTH);

  logic [W-1:0]  mem_r [RAS_DEPTH];
  logic [PW-1:0] top_r;
  logic [PW:0]   count_r;
  logic          ovf_r;
  logic [PW-1:0] wr_ptr_s;
  logic          full_s;

  assign wr_ptr_s = top_r + PW'(1);
  assign full_s   = (count_r == DEPTH_C);

  // Stack storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_r[wr_ptr_s] <= push_data;
    end
  end

  // Top pointer, occupancy count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_r   <= {PW{1'b1}};
      count_r <= {(PW + 1){1'b0}};
      ovf_r   <= 1'b0;
    end else if (push) begin
      top_r <= wr_ptr_s;
      if (full_s) begin
        ovf_r <= 1'b1;
      end else begin
        count_r <= count_r + (PW + 1)'(1);
      end
    end else if (pop) begin
      top_r   <= top_r - PW'(1);
      count_r <= count_r - (PW + 1)'(1);
    end
  end

  assign top   = mem_r[top_r];
  assign full  = full_s;
  assign empty = (count_r == {(PW + 1){1'b0}});
  assign ovf   = ovf_r;

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with branch/jump/call/return and alignment checks.
// Define PC_SEQ_TRAP_EN to add the trap input and exception PC register.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter int unsigned STEP       = 4,
  parameter logic [W-1:0] RESET_VEC = {W{1'b0}},
  parameter int unsigned RAS_DEPTH  = 4,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic         clk,
  input  logic         reset,
`ifdef PC_SEQ_TRAP_EN
  input  logic         trap,
  input  logic [W-1:0] trap_vec,
  output logic [W-1:0] epc,
`endif
  input  logic         en,
  input  logic         stall,
  input  logic [2:0]   op,
  input  logic [W-1:0] target,
  input  logic [W-1:0] offset,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_next,
  output logic         ras_full,
  output logic         ras_empty,
  output logic         ras_ovf,
  output logic         err_misalign,
  output logic         err_underflow
);

  logic [W-1:0] pc_r;
  logic [W-1:0] pc_next_s;
  logic [W-1:0] seq_s;
  logic [W-1:0] branch_s;
  logic [W-1:0] ras_top_s;
  logic         ras_empty_s;
  logic         push_s;
  logic         pop_s;
  logic         misalign_s;
  logic         underflow_s;
  logic         err_misalign_r;
  logic         err_underflow_r;
  logic         trap_take_s;
  logic [W-1:0] trap_vec_s;

  assign seq_s    = pc_r + W'(STEP);
  assign branch_s = pc_r + offset;

`ifdef PC_SEQ_TRAP_EN
  logic [W-1:0] epc_r;
  assign trap_take_s = trap;
  assign trap_vec_s  = trap_vec;
  assign epc         = epc_r;

  // Exception PC captures the interrupted pc when a trap is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_r <= {W{1'b0}};
    end else if (trap && !stall) begin
      epc_r <= pc_r;
    end
  end
`else
  assign trap_take_s = 1'b0;
  assign trap_vec_s  = {W{1'b0}};
`endif

  // Next-PC selection; rejected ops leave pc alone and raise an error.
  always_comb begin
    pc_next_s   = pc_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    misalign_s  = 1'b0;
    underflow_s = 1'b0;
    if (reset) begin
      pc_next_s = RESET_VEC;
    end else if (stall) begin
      pc_next_s = pc_r;
    end else if (trap_take_s) begin
      pc_next_s = trap_vec_s;
    end else if (en) begin
      case (op)
        OP_HOLD: pc_next_s = pc_r;
        OP_INC:  pc_next_s = seq_s;
        OP_BRANCH: begin
          if (is_aligned(64'(branch_s), ALIGN_BITS)) pc_next_s = branch_s;
          else misalign_s = 1'b1;
        end
        OP_JUMP: begin
          if (is_aligned(64'(target), ALIGN_BITS)) pc_next_s = target;
          else misalign_s = 1'b1;
        end
        OP_CALL: begin
          if (is_aligned(64'(target), ALIGN_BITS)) begin
            pc_next_s = target;
            push_s    = 1'b1;
          end else begin
            misalign_s = 1'b1;
          end
        end
        OP_RET: begin
          if (ras_empty_s) begin
            underflow_s = 1'b1;
          end else begin
            pc_next_s = ras_top_s;
            pop_s     = 1'b1;
          end
        end
        default: pc_next_s = pc_r;
      endcase
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r            <= RESET_VEC;
      err_misalign_r  <= 1'b0;
      err_underflow_r <= 1'b0;
    end else begin
      pc_r            <= pc_next_s;
      err_misalign_r  <= misalign_s;
      err_underflow_r <= underflow_s;
    end
  end

  pc_ras #(
    .W         (W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (seq_s),
    .top       (ras_top_s),
    .full      (ras_full),
    .empty     (ras_empty_s),
    .ovf       (ras_ovf)
  );

  assign pc            = pc_r;
  assign pc_next       = pc_next_s;
  assign ras_empty     = ras_empty_s;
  assign err_misalign  = err_misalign_r;
  assign err_underflow = err_underflow_r;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: queue-based reference model plus directed literal checks.
module tb_pc_seq;

  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, BRANCH = 3'd2, JUMP = 3'd3, CALL = 3'd4, RET = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] target = 32'd0;
  logic [31:0] offset = 32'd0;
  logic [31:0] pc, pc_next;
  logic        ras_full, ras_empty, ras_ovf, err_misalign, err_underflow;
`ifdef PC_SEQ_TRAP_EN
  logic        trap = 1'b0;
  logic [31:0] trap_vec = 32'd0;
  logic [31:0] epc;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];
  bit m_ovf, m_mis, m_und, m_valid;

  pc_seq dut (
    .clk(clk), .reset(reset),
`ifdef PC_SEQ_TRAP_EN
    .trap(trap), .trap_vec(trap_vec), .epc(epc),
`endif
    .en(en), .stall(stall), .op(op), .target(target), .offset(offset),
    .pc(pc), .pc_next(pc_next), .ras_full(ras_full), .ras_empty(ras_empty),
    .ras_ovf(ras_ovf), .err_misalign(err_misalign), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge's worth of architectural rules to the model state.
  task automatic model_step();
    logic [31:0] d;
    if (reset) begin
      m_pc = 32'd0; m_epc = 32'd0; m_ras.delete(); m_ovf = 0; m_mis = 0; m_und = 0; m_valid = 1;
    end else begin
      m_mis = 0; m_und = 0;
      if (!stall) begin
`ifdef PC_SEQ_TRAP_EN
        if (trap) begin
          m_epc = m_pc; m_pc = trap_vec;
        end else
`endif
        if (en) begin
          case (op)
            INC: m_pc = m_pc + 32'd4;
            BRANCH: begin
              d = m_pc + offset;
              if (d % 4 != 0) m_mis = 1; else m_pc = d;
            end
            JUMP: if (target % 4 != 0) m_mis = 1; else m_pc = target;
            CALL: begin
              if (target % 4 != 0) m_mis = 1;
              else begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > 4) begin
                  void'(m_ras.pop_front());
                  m_ovf = 1;
                end
                m_pc = target;
              end
            end
            RET: if (m_ras.size() == 0) m_und = 1; else m_pc = m_ras.pop_back();
            default: ;
          endcase
        end
      end
    end
  endtask

  // Single comparison process, mid-cycle, against the model.
  always @(negedge clk) begin
    logic [31:0] s_pc, s_epc, pred;
    logic [31:0] s_ras[$];
    bit s_ovf, s_mis, s_und;
    if (m_valid) begin
      check("pc", pc, m_pc);
      check("ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
      check("ras_full", {31'd0, ras_full}, {31'd0, m_ras.size() == 4});
      check("ras_ovf", {31'd0, ras_ovf}, {31'd0, m_ovf});
      check("err_misalign", {31'd0, err_misalign}, {31'd0, m_mis});
      check("err_underflow", {31'd0, err_underflow}, {31'd0, m_und});
`ifdef PC_SEQ_TRAP_EN
      check("epc", epc, m_epc);
`endif
      s_pc = m_pc; s_epc = m_epc; s_ras = m_ras; s_ovf = m_ovf; s_mis = m_mis; s_und = m_und;
      model_step();
      pred = m_pc;
      m_pc = s_pc; m_epc = s_epc; m_ras = s_ras; m_ovf = s_ovf; m_mis = s_mis; m_und = s_und;
      check("pc_next", pc_next, pred);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] t, input logic [31:0] off, input logic s);
    en = 1'b1; op = o; target = t; offset = off; stall = s;
    tick();
  endtask

  initial begin
    tick(); tick();
    check("reset_pc", pc, 32'h0);
    check("reset_empty", {31'd0, ras_empty}, 32'd1);
    check("reset_full", {31'd0, ras_full}, 32'd0);
    reset = 1'b0;

    // sequential increments with a stall on the second
    do_op(INC, 0, 0, 0);   check("inc1", pc, 32'h4);
    do_op(INC, 0, 0, 1);   check("inc_stall", pc, 32'h4);
    do_op(INC, 0, 0, 0);   check("inc2", pc, 32'h8);
    do_op(INC, 0, 0, 0);   check("inc3", pc, 32'hC);
    en = 1'b0; op = INC; tick(); check("en_low_hold", pc, 32'hC);
    do_op(3'd6, 32'h80, 0, 0); check("op6_hold", pc, 32'hC);

    // branch backwards, then a misaligned jump
    do_op(JUMP, 32'h100, 0, 0);          check("jump", pc, 32'h100);
    do_op(BRANCH, 0, 32'hFFFF_FFF0, 0);  check("branch_neg", pc, 32'hF0);
    do_op(JUMP, 32'h202, 0, 0);          check("misalign_pc", pc, 32'hF0);
    check("misalign_pulse", {31'd0, err_misalign}, 32'd1);
    do_op(HOLD, 0, 0, 0);                check("misalign_clear", {31'd0, err_misalign}, 32'd0);
    do_op(BRANCH, 0, 32'h6, 0);          check("branch_misalign", pc, 32'hF0);

    // nested call/return
    do_op(JUMP, 32'h10, 0, 0);
    do_op(CALL, 32'h400, 0, 0);  check("call1", pc, 32'h400);
    do_op(CALL, 32'h800, 0, 0);  check("call2", pc, 32'h800);
    do_op(CALL, 32'h801, 0, 0);  check("call_misalign", pc, 32'h800);
    do_op(RET, 0, 0, 0);         check("ret1", pc, 32'h404);
    do_op(RET, 0, 0, 0);         check("ret2", pc, 32'h14);
    check("ret_empty", {31'd0, ras_empty}, 32'd1);

    // overflow the stack then drain it past empty
    do_op(CALL, 32'h1000, 0, 0);
    do_op(CALL, 32'h2000, 0, 0);
    do_op(CALL, 32'h3000, 0, 0);
    do_op(CALL, 32'h4000, 0, 0);
    check("full_after4", {31'd0, ras_full}, 32'd1);
    check("no_ovf_after4", {31'd0, ras_ovf}, 32'd0);
    do_op(CALL, 32'h5000, 0, 0);
    check("ovf_after5", {31'd0, ras_ovf}, 32'd1);
    do_op(RET, 0, 0, 0); check("ovf_ret1", pc, 32'h4004);
    do_op(RET, 0, 0, 0); check("ovf_ret2", pc, 32'h3004);
    do_op(RET, 0, 0, 0); check("ovf_ret3", pc, 32'h2004);
    do_op(RET, 0, 0, 0); check("ovf_ret4", pc, 32'h1004);
    do_op(RET, 0, 0, 0); check("underflow_pc", pc, 32'h1004);
    check("underflow_pulse", {31'd0, err_underflow}, 32'd1);
    check("ovf_sticky", {31'd0, ras_ovf}, 32'd1);

    // wrap-around and reset overriding a pending call
    do_op(JUMP, 32'hFFFF_FFFC, 0, 0);
    do_op(INC, 0, 0, 0);  check("wrap", pc, 32'h0);
    do_op(CALL, 32'h40, 0, 0);
    reset = 1'b1; do_op(CALL, 32'h80, 0, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_empty", {31'd0, ras_empty}, 32'd1);
    check("rst_ovf", {31'd0, ras_ovf}, 32'd0);
    reset = 1'b0;

`ifdef PC_SEQ_TRAP_EN
    do_op(JUMP, 32'h40, 0, 0);
    trap = 1'b1; trap_vec = 32'h1000;
    do_op(INC, 0, 0, 0);
    check("trap_pc", pc, 32'h1000);
    check("trap_epc", epc, 32'h40);
    trap = 1'b0; do_op(JUMP, 32'h80, 0, 0);
    trap = 1'b1; trap_vec = 32'h2000;
    do_op(INC, 0, 0, 1);
    check("trap_stall_pc", pc, 32'h80);
    check("trap_stall_epc", epc, 32'h40);
    trap = 1'b0;
`endif

    do_op(HOLD, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised program-counter sequencer; next generation of the CPU's PC register.
- Adds configurable width/step, relative branch, absolute jump, call/return via an internal return-address stack (RAS), stall, and alignment checking.
- Sits between fetch and decode/branch logic; drives the instruction-memory address.

Parameters:
- W, 32, PC width in bits.
- STEP, 4, sequential increment in bytes.
- RESET_VEC, 0, PC value after reset.
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).
- ALIGN_BITS, 2, low PC bits that must be zero.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  apply op this cycle; low = hold.
- stall  in  1  overrides en; PC and RAS hold.
- op  in  3  0 HOLD, 1 INC, 2 BRANCH, 3 JUMP, 4 CALL, 5 RET; 6–7 treated as HOLD.
- target  in  W  absolute target for JUMP/CALL.
- offset  in  W  two's-complement offset for BRANCH, relative to the current pc.
- pc  out  W  current program counter.
- pc_next  out  W  combinational value pc will take at the next edge.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_empty  out  1  RAS holds 0 entries.
- ras_ovf  out  1  sticky; set when a CALL overwrites the oldest entry.
- err_misalign  out  1  one-cycle pulse; an op was rejected for misalignment.
- err_underflow  out  1  one-cycle pulse; RET issued on an empty RAS.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (highest priority):
  - pc=RESET_VEC; RAS count=0; ras_empty=1, ras_full=0; ras_ovf=0; error pulses=0.
  - Reset asserted mid-sequence discards any pending op.
- Update condition: the op takes effect at the edge when en=1 and stall=0. Otherwise pc, RAS and ras_ovf hold, and error pulses are 0 next cycle.
- Latency: pc_next reflects the op combinationally; pc updates on the next edge (1 cycle).
- Operations (all arithmetic modulo 2^W, wrap silently; e.g. pc=2^W−STEP, INC → 0):
  - HOLD: pc unchanged.
  - INC: pc <= pc+STEP.
  - BRANCH: pc <= pc+offset.
  - JUMP: pc <= target.
  - CALL: push pc+STEP onto RAS; pc <= target.
  - RET: pc <= top of RAS; pop.
- Alignment:
  - Applies to BRANCH, JUMP and CALL: if the computed destination's low ALIGN_BITS bits are nonzero, pc holds, RAS is unchanged, and err_misalign=1 for one cycle.
  - INC is not checked.
- RAS:
  - Circular, with top-of-stack pointer and count.
  - CALL on full: overwrite oldest entry, count stays RAS_DEPTH, ras_ovf<=1 (cleared only by reset).
  - RET on empty: pc holds, err_underflow=1 for one cycle.
  - Pops never clear ras_ovf.
  - Push value is computed from the pre-update pc.
- Errors: err_misalign and err_underflow are registered and mutually exclusive, since one op is applied per cycle.

Optional Feature:
- Macro: PC_SEQ_TRAP_EN.
- Defined:
  - Adds ports trap (in 1), trap_vec (in W), epc (out W).
  - trap=1 and stall=0 at an edge:
    - epc <= pc; pc <= trap_vec.
    - Overrides en/op; RAS untouched; alignment not checked.
  - trap outranks stall = no; stall still freezes.
  - epc resets to 0.
- Undefined: no trap ports; no epc register.

Decomposition:
- Package pc_seq_pkg:
  - op encoding constants (OP_HOLD..OP_RET).
  - function for the alignment check.
- Sub-module pc_ras:
  - Parameters W, RAS_DEPTH.
  - Ports: push, pop, push_data, top, full, empty, ovf.
  - Owns pointer/count logic.
- pc_seq holds the PC register, next-PC mux and error pulses.

Test Plan:
- Reset then INC ×3 (W=32, STEP=4) → pc 0,4,8,12; stall=1 on 2nd INC holds pc at 4 for that cycle.
- pc=0x100, BRANCH offset=0xFFFFFFF0 → pc=0xF0; JUMP target=0x202 → pc stays 0xF0, err_misalign pulses 1 cycle.
- pc=0x10, CALL 0x400; CALL 0x800; RET; RET → pc 0x400, 0x800, 0x404, 0x14; ras_empty=1 at end.
- RAS_DEPTH=4: 5 CALLs then 5 RETs → ras_full after 4th, ras_ovf=1 after 5th; 4 RETs return newest-first; 5th RET → err_underflow, pc holds.
- pc=0xFFFFFFFC, INC → pc=0x0; reset asserted with en=1, op=CALL → pc=RESET_VEC, ras_empty=1, ras_ovf=0.
- PC_SEQ_TRAP_EN: pc=0x40, trap=1, trap_vec=0x1000 → pc=0x1000, epc=0x40; same with stall=1 → no change.
